// File: rtl/o1o2_compare_monitor.sv
// Runtime o1 == o2 checker for a dual-output unit: after a settle window it
// compares both outputs every cycle and reports mismatches on registered outputs.
module o1o2_compare_monitor #(
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             o1,
  input  logic             o2,
  output logic             armed,
  output logic             err,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ARMED,
    ST_FAULT
  } state_t;

  state_t          state;
  logic [SC_W-1:0] settle_cnt;
  logic            mismatch;

  assign mismatch = (o1 != o2);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; rst is tested first so it overrides en, clr and the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      armed         <= 1'b0;
      err           <= 1'b0;
      err_pulse     <= 1'b0;
      err_cnt       <= '0;
      first_err_cyc <= '0;
      cyc_cnt       <= '0;
    end else begin
      err_pulse <= 1'b0;

      if (clr) begin
        err           <= 1'b0;
        err_cnt       <= '0;
        first_err_cyc <= '0;
        cyc_cnt       <= '0;
      end

      if (!en) begin
        state      <= ST_IDLE;
        armed      <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          // The enabling edge counts as the first settle edge.
          ST_IDLE: begin
            settle_cnt <= SC_W'(1);
            if (SETTLE <= 1) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end else begin
              state <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (int'(settle_cnt) + 1 >= SETTLE) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + SC_W'(1);
            end
          end
          default: begin
            if (clr) begin
              state <= ST_ARMED;
            end else begin
              if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
              if (mismatch) begin
                state     <= ST_FAULT;
                err       <= 1'b1;
                err_pulse <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (!err) first_err_cyc <= cyc_cnt;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_o1o2_compare_monitor.sv
// Directed bench for o1o2_compare_monitor: a default instance plus a narrow,
// zero-settle instance used for saturation checks.
module tb_o1o2_compare_monitor;

  logic clk = 1'b0;
  logic rst, en, clr, o1, o2;

  logic        armed, err, err_pulse;
  logic [7:0]  err_cnt;
  logic [15:0] first_err_cyc, cyc_cnt;

  logic       s_armed, s_err, s_err_pulse;
  logic [1:0] s_err_cnt;
  logic [2:0] s_first_err_cyc, s_cyc_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  o1o2_compare_monitor dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .o1(o1), .o2(o2),
    .armed(armed), .err(err), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .first_err_cyc(first_err_cyc), .cyc_cnt(cyc_cnt)
  );

  o1o2_compare_monitor #(.CNT_W(3), .ERR_W(2), .SETTLE(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .o1(o1), .o2(o2),
    .armed(s_armed), .err(s_err), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
    .first_err_cyc(s_first_err_cyc), .cyc_cnt(s_cyc_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; o1 = 1'b0; o2 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({armed, err, err_pulse} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b want 000", {armed, err, err_pulse});
    end
    n_checks++;
    if ({err_cnt, first_err_cyc, cyc_cnt} !== 40'd0) begin
      n_errors++;
      $display("FAIL reset_counters: got err_cnt=%0d first=%0d cyc=%0d want 0/0/0",
               err_cnt, first_err_cyc, cyc_cnt);
    end
  endtask

  task automatic test_settle();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (armed !== 1'b0) begin
      n_errors++;
      $display("FAIL settle_not_armed_3: got %b want 0", armed);
    end
    step();
    n_checks++;
    if (armed !== 1'b1) begin
      n_errors++;
      $display("FAIL settle_armed_4: got %b want 1", armed);
    end
    for (int i = 0; i < 16; i++) begin
      o1 = i[0];
      o2 = i[0];
      step();
    end
    n_checks++;
    if ({err, err_pulse, cyc_cnt} !== {2'b00, 16'd16}) begin
      n_errors++;
      $display("FAIL settle_cyc_cnt: got err=%b cyc=%0d want err=0 cyc=16", err, cyc_cnt);
    end
  endtask

  task automatic test_first_mismatch();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    step();
    step();
    o1 = 1'b1; o2 = 1'b0;
    step();
    n_checks++;
    if ({armed, err, err_pulse, err_cnt, first_err_cyc, cyc_cnt} !==
        {3'b111, 8'd1, 16'd2, 16'd3}) begin
      n_errors++;
      $display("FAIL first_mismatch: got armed=%b err=%b pulse=%b cnt=%0d first=%0d cyc=%0d want 1/1/1/1/2/3",
               armed, err, err_pulse, err_cnt, first_err_cyc, cyc_cnt);
    end
    o1 = 1'b0;
    step();
    n_checks++;
    if ({err, err_pulse} !== 2'b10) begin
      n_errors++;
      $display("FAIL first_mismatch_after: got err=%b pulse=%b want 1/0", err, err_pulse);
    end
  endtask

  task automatic test_multi_mismatch();
    logic [4:0] pat;
    logic [4:0] got;
    pat = 5'b01101;
    for (int i = 4; i >= 0; i--) begin
      o1 = pat[i];
      o2 = 1'b0;
      step();
      got[i] = err_pulse;
    end
    n_checks++;
    if (got !== pat) begin
      n_errors++;
      $display("FAIL multi_pulse_pattern: got %b want %b", got, pat);
    end
    n_checks++;
    if ({err_cnt, first_err_cyc, cyc_cnt} !== {8'd4, 16'd2, 16'd9}) begin
      n_errors++;
      $display("FAIL multi_counters: got cnt=%0d first=%0d cyc=%0d want 4/2/9",
               err_cnt, first_err_cyc, cyc_cnt);
    end
  endtask

  task automatic test_clr_with_mismatch();
    clr = 1'b1; o1 = 1'b1; o2 = 1'b0;
    step();
    n_checks++;
    if ({armed, err, err_pulse, err_cnt, first_err_cyc, cyc_cnt} !== {3'b100, 40'd0}) begin
      n_errors++;
      $display("FAIL clr_mismatch: got armed=%b err=%b pulse=%b cnt=%0d first=%0d cyc=%0d want 1/0/0/0/0/0",
               armed, err, err_pulse, err_cnt, first_err_cyc, cyc_cnt);
    end
    clr = 1'b0; o1 = 1'b0;
    step();
    n_checks++;
    if ({armed, err, cyc_cnt} !== {2'b10, 16'd1}) begin
      n_errors++;
      $display("FAIL clr_resume: got armed=%b err=%b cyc=%0d want 1/0/1", armed, err, cyc_cnt);
    end
    o1 = 1'b1;
    step();
    n_checks++;
    if ({err, err_pulse, err_cnt, first_err_cyc} !== {2'b11, 8'd1, 16'd1}) begin
      n_errors++;
      $display("FAIL clr_recapture: got err=%b pulse=%b cnt=%0d first=%0d want 1/1/1/1",
               err, err_pulse, err_cnt, first_err_cyc);
    end
    o1 = 1'b0;
  endtask

  task automatic test_saturation();
    int pulses;
    do_reset();
    en = 1'b1;
    step();
    n_checks++;
    if (s_armed !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_zero_settle_armed: got %b want 1", s_armed);
    end
    pulses = 0;
    o1 = 1'b1; o2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_err_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 6) begin
      n_errors++;
      $display("FAIL sat_pulse_count: got %0d want 6", pulses);
    end
    n_checks++;
    if ({s_err_cnt, s_first_err_cyc, s_cyc_cnt} !== {2'd3, 3'd0, 3'd6}) begin
      n_errors++;
      $display("FAIL sat_counters: got cnt=%0d first=%0d cyc=%0d want 3/0/6",
               s_err_cnt, s_first_err_cyc, s_cyc_cnt);
    end
    o1 = 1'b0;
    step();
    step();
    n_checks++;
    if ({s_err_pulse, s_cyc_cnt} !== {1'b0, 3'd7}) begin
      n_errors++;
      $display("FAIL sat_cyc_hold: got pulse=%b cyc=%0d want 0/7", s_err_pulse, s_cyc_cnt);
    end
  endtask

  task automatic test_rst_and_en_drop();
    do_reset();
    en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({armed, err, cyc_cnt} !== {2'b00, 16'd0}) begin
      n_errors++;
      $display("FAIL rst_mid_settle: got armed=%b err=%b cyc=%0d want 0/0/0", armed, err, cyc_cnt);
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (armed !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_settle_restart: got armed=%b want 0", armed);
    end
    step();
    o1 = 1'b1;
    step();
    en = 1'b0;
    step();
    n_checks++;
    if ({armed, err, err_pulse, err_cnt, cyc_cnt} !== {3'b010, 8'd1, 16'd1}) begin
      n_errors++;
      $display("FAIL en_drop_fault: got armed=%b err=%b pulse=%b cnt=%0d cyc=%0d want 0/1/0/1/1",
               armed, err, err_pulse, err_cnt, cyc_cnt);
    end
    o1 = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if ({armed, err} !== 2'b01) begin
      n_errors++;
      $display("FAIL en_resettle: got armed=%b err=%b want 0/1", armed, err);
    end
    step();
    n_checks++;
    if (armed !== 1'b1) begin
      n_errors++;
      $display("FAIL en_rearmed: got armed=%b want 1", armed);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({armed, err, err_cnt} !== {2'b00, 8'd0}) begin
      n_errors++;
      $display("FAIL rst_in_fault: got armed=%b err=%b cnt=%0d want 0/0/0", armed, err, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_first_mismatch();
    test_multi_mismatch();
    test_clr_with_mismatch();
    test_saturation();
    test_rst_and_en_drop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
